// File: rtl/shake256_pkg.sv
// Shared constants and types for the SHAKE256 absorb sequencer.
package shake256_pkg;

  localparam int RATE_BITS  = 1088;
  localparam int WORD_BITS  = 64;
  localparam int RATE_WORDS = 17;
  localparam int LEN_BITS   = 11;

  typedef logic [1087:0] rate_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT      = 2'd1,
    EMIT_NEXT = 2'd2
  } absorb_state_t;

endpackage

// File: rtl/shake256_absorb_ctrl_pad.sv
// SHAKE256 rate-block padder: keeps data_length bits of data_in, appends 0x1F and a
// closing 0x80; when the message fills the block, the padding moves to data_next.
module pad #(
  parameter int WIDTH = 1088,
  parameter int LEN_W = 11
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] data_length,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_next
);

  localparam int NBYTES = WIDTH / 8;

  logic [LEN_W-1:0] w_nb;

  // Byte-granular keep/terminate, then the closing bit in the last rate byte.
  always_comb begin
    w_nb      = (data_length + LEN_W'(7)) >> 3;
    data_out  = '0;
    data_next = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < int'(w_nb)) data_out[WIDTH-1-8*b -: 8] = data_in[WIDTH-1-8*b -: 8];
      else if (b == int'(w_nb)) data_out[WIDTH-1-8*b -: 8] = 8'h1F;
      else data_out[WIDTH-1-8*b -: 8] = 8'h00;
    end
    if (int'(w_nb) < NBYTES) begin
      data_out[7:0] = data_out[7:0] | 8'h80;
    end else begin
      data_next[WIDTH-1 -: 8] = 8'h1F;
      data_next[7:0]          = 8'h80;
    end
  end

endmodule

// File: rtl/shake256_absorb_ctrl.sv
// SHAKE256 absorb sequencer: packs 64-bit words into rate blocks, pads the tail.
// Optional SHAKE_ABSORB_STATS_EN adds a wrapping handshake counter on blk_count.
module shake256_absorb_ctrl #(
  parameter int RATE_BITS = 1088,
  parameter int WORD_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_last,
  input  logic [3:0]           in_bytes,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_first,
  output logic                 blk_last
`ifdef SHAKE_ABSORB_STATS_EN
  ,
  output logic [15:0]          blk_count
`endif
);

  import shake256_pkg::*;

  localparam logic [4:0]          LAST_SLOT = 5'(RATE_BITS / WORD_BITS - 1);
  localparam logic [LEN_BITS-1:0] FULL_LEN  = LEN_BITS'(RATE_BITS);

  absorb_state_t        r_state, w_state_nxt;
  logic [4:0]           r_ptr;
  logic [RATE_BITS-1:0] r_asm, w_asm, w_pad_out, w_pad_next, r_spill, r_blk_data;
  logic                 r_first, r_ovf, r_blk_first, r_blk_last;
  logic [3:0]           w_nbytes;
  logic [WORD_BITS-1:0] w_word;
  logic [LEN_BITS-1:0]  w_len;
  logic                 w_acc, w_blk_hs;

  assign w_acc     = in_valid && (r_state == FILL);
  assign w_blk_hs  = (r_state != FILL) && blk_ready;
  assign in_ready  = (r_state == FILL);
  assign blk_valid = (r_state != FILL);
  assign blk_data  = r_blk_data;
  assign blk_first = r_blk_first;
  assign blk_last  = r_blk_last;

  // Clamp the byte count and zero the unused tail bytes of a final word.
  always_comb begin
    w_nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    w_word   = in_data;
    for (int b = 0; b < WORD_BITS / 8; b++) begin
      if (in_last && (b >= int'(w_nbytes))) w_word[WORD_BITS-1-8*b -: 8] = 8'h00;
      else w_word[WORD_BITS-1-8*b -: 8] = in_data[WORD_BITS-1-8*b -: 8];
    end
  end

  // Block as it will look once the incoming word lands in slot ptr.
  always_comb begin
    w_asm = r_asm;
    w_asm[RATE_BITS-1-WORD_BITS*int'(r_ptr) -: WORD_BITS] = w_word;
    w_len = {r_ptr, 6'd0} + {4'd0, w_nbytes, 3'd0};
  end

  pad #(
    .WIDTH (RATE_BITS),
    .LEN_W (LEN_BITS)
  ) u_pad (
    .data_in     (w_asm),
    .data_length (w_len),
    .data_out    (w_pad_out),
    .data_next   (w_pad_next)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (w_acc && (in_last || (r_ptr == LAST_SLOT))) w_state_nxt = EMIT;
        else w_state_nxt = FILL;
      end
      EMIT: begin
        if (blk_ready) w_state_nxt = r_ovf ? EMIT_NEXT : FILL;
        else w_state_nxt = EMIT;
      end
      EMIT_NEXT: begin
        if (blk_ready) w_state_nxt = FILL;
        else w_state_nxt = EMIT_NEXT;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Assembly, output and spill registers. A handshake re-arms the first flag
  // exactly when the block just taken was the message's last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 5'd0;
      r_asm       <= '0;
      r_spill     <= '0;
      r_blk_data  <= '0;
      r_first     <= 1'b1;
      r_ovf       <= 1'b0;
      r_blk_first <= 1'b0;
      r_blk_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_asm <= w_asm;
        if (in_last) begin
          r_blk_data  <= w_pad_out;
          r_spill     <= w_pad_next;
          r_ovf       <= (w_len == FULL_LEN);
          r_blk_last  <= (w_len != FULL_LEN);
          r_blk_first <= r_first;
          r_ptr       <= 5'd0;
        end else if (r_ptr == LAST_SLOT) begin
          r_blk_data  <= w_asm;
          r_ovf       <= 1'b0;
          r_blk_last  <= 1'b0;
          r_blk_first <= r_first;
          r_ptr       <= 5'd0;
        end else begin
          r_ptr <= r_ptr + 5'd1;
        end
      end
      if (w_blk_hs) begin
        r_first <= r_blk_last;
        if ((r_state == EMIT) && r_ovf) begin
          r_blk_data  <= r_spill;
          r_blk_first <= 1'b0;
          r_blk_last  <= 1'b1;
          r_ovf       <= 1'b0;
        end
      end
    end
  end

`ifdef SHAKE_ABSORB_STATS_EN
  logic [15:0] r_blk_count;

  // Handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_blk_count <= 16'd0;
    else if (w_blk_hs) r_blk_count <= r_blk_count + 16'd1;
  end

  assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_shake256_absorb_ctrl.sv
// Self-checking bench: byte-level SHAKE256 padding model vs. the absorb sequencer.
module tb_shake256_absorb_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [63:0]   in_data = 64'd0;
  logic [3:0]    in_bytes = 4'd0;
  logic          blk_ready = 1'b0;
  logic          in_ready, blk_valid, blk_first, blk_last;
  logic [1087:0] blk_data;
`ifdef SHAKE_ABSORB_STATS_EN
  logic [15:0]   blk_count;
`endif

  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;
  logic manual_ready = 1'b0;

  typedef struct {
    logic [1087:0] d;
    logic          f;
    logic          l;
  } cap_t;
  cap_t cap[$];

  typedef struct {
    int nw;
    int lb;
    int nexp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  shake256_absorb_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
`ifdef SHAKE_ABSORB_STATS_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       blk_ready = 1'b1;
      1:       blk_ready = 1'($urandom_range(0, 1));
      default: blk_ready = manual_ready;
    endcase
  end

  always @(negedge clk) begin
    cap_t c;
    if (blk_valid && blk_ready) begin
      c.d = blk_data;
      c.f = blk_first;
      c.l = blk_last;
      cap.push_back(c);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [1087:0] got, input logic [1087:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int w = 0; w < 17; w++) begin
        if (got[1087-64*w -: 64] !== exp[1087-64*w -: 64]) begin
          $display("FAIL %s word%0d got=%h exp=%h", name, w, got[1087-64*w -: 64], exp[1087-64*w -: 64]);
          break;
        end
      end
    end
  endtask

  // Reference: append 0x1F, zero-fill to a multiple of 136 bytes, OR 0x80 into the final byte.
  function automatic void model(input byte unsigned msg[$], output logic [1087:0] blks[$]);
    byte unsigned  p[$];
    logic [1087:0] b;
    p = msg;
    p.push_back(8'h1F);
    while (p.size() % 136 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    blks = {};
    for (int k = 0; k < p.size() / 136; k++) begin
      b = '0;
      for (int i = 0; i < 136; i++) b[1087-8*i -: 8] = p[k*136+i];
      blks.push_back(b);
    end
  endfunction

  task automatic send_msg(input int nw, input int lb, input bit do_last, input bit gaps,
                          output byte unsigned msg[$]);
    msg = {};
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      bit          last;
      int          nb;
      int          t;
      d    = {$urandom, $urandom};
      last = do_last && (w == nw - 1);
      nb   = last ? ((lb > 8) ? 8 : lb) : 8;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_bytes = last ? 4'(lb) : 4'($urandom_range(0, 15));
      t = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 1000) begin
          checks++;
          errors++;
          $display("FAIL word_accept_timeout got=stalled exp=accepted");
          break;
        end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < nb; b++) msg.push_back(d[63-8*b -: 8]);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_blocks(input int id, input byte unsigned msg[$], input int nexp_in);
    logic [1087:0] exp[$];
    int            nexp;
    int            t;
    model(msg, exp);
    nexp = (nexp_in < 0) ? exp.size() : nexp_in;
    t = 0;
    while (cap.size() < nexp && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (4) begin @(posedge clk); #1; end
    check($sformatf("msg%0d_nblocks", id), 64'(cap.size()), 64'(nexp));
    for (int k = 0; k < exp.size() && k < cap.size(); k++) begin
      check_blk($sformatf("msg%0d_blk%0d_data", id, k), cap[k].d, exp[k]);
      check($sformatf("msg%0d_blk%0d_first", id, k), 64'(cap[k].f), 64'(k == 0));
      check($sformatf("msg%0d_blk%0d_last", id, k), 64'(cap[k].l), 64'(k == exp.size() - 1));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    byte unsigned  msg[$];
    logic [1087:0] snap;

    vecs[0] = '{1, 0, 1};
    vecs[1] = '{1, 5, 1};
    vecs[2] = '{17, 8, 2};
    vecs[3] = '{25, 8, 2};
    vecs[4] = '{17, 0, 1};
    vecs[5] = '{18, 0, 2};
    vecs[6] = '{17, 7, 1};
    vecs[7] = '{34, 8, 3};
    vecs[8] = '{3, 12, 1};
    vecs[9] = '{16, 15, 1};

    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_blk_valid", 64'(blk_valid), 64'd0);
    check_blk("rst_blk_data", blk_data, '0);
    check("rst_blk_first", 64'(blk_first), 64'd0);
    check("rst_blk_last", 64'(blk_last), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ready_mode = (i % 3 == 2) ? 1 : 0;
      cap = {};
      send_msg(vecs[i].nw, vecs[i].lb, 1'b1, 1'b0, msg);
      expect_blocks(i, msg, vecs[i].nexp);
    end

    // Backpressure: block held in EMIT for 10 cycles while a word waits.
    ready_mode   = 2;
    manual_ready = 1'b0;
    cap = {};
    send_msg(1, 5, 1'b1, 1'b0, msg);
    check("bp_latency_blk_valid", 64'(blk_valid), 64'd1);
    snap     = blk_data;
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0123_4567;
    in_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_blk("bp_data_stable", blk_data, snap);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_blk_valid", 64'(blk_valid), 64'd1);
    end
    @(posedge clk);
    in_valid     = 1'b0;
    manual_ready = 1'b1;
    expect_blocks(100, msg, 1);
    ready_mode   = 0;
    manual_ready = 1'b0;

    // Mid-message reset discards partial state.
    cap = {};
    send_msg(9, 8, 1'b0, 1'b0, msg);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_blk_valid", 64'(blk_valid), 64'd0);
    check_blk("midrst_blk_data", blk_data, '0);
    check("midrst_blk_first", 64'(blk_first), 64'd0);
    check("midrst_blk_last", 64'(blk_last), 64'd0);
`ifdef SHAKE_ABSORB_STATS_EN
    check("midrst_blk_count", 64'(blk_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap = {};
    send_msg(1, 8, 1'b1, 1'b0, msg);
    expect_blocks(101, msg, 1);
`ifdef SHAKE_ABSORB_STATS_EN
    check("post_rst_blk_count", 64'(blk_count), 64'd1);
`endif

    // Randomized messages with input gaps and random backpressure.
    for (int r = 0; r < 25; r++) begin
      ready_mode = $urandom_range(0, 1);
      cap = {};
      send_msg($urandom_range(1, 40), $urandom_range(0, 15), 1'b1, 1'b1, msg);
      expect_blocks(200 + r, msg, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shake256_absorb_ctrl.md
# shake256_absorb_ctrl

Absorb-phase sequencer for the SHAKE256 core. Accepts a message as a stream of 64-bit words, assembles 1088-bit rate blocks, and runs the final partial block through the `pad` datapath. If padding spills into an extra block, it issues that block too. Blocks go to the Keccak permutation core over a valid/ready handshake, tagged first/last so the core can clear its state and start squeezing.

## Interface
Parameters:
- RATE_BITS, 1088, SHAKE256 rate; must equal `pad` width.
- WORD_BITS, 64, input word width; RATE_BITS/WORD_BITS = 17 words per block.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  64  message word; byte 0 in bits [63:56].
- in_last  in  1  word is the final word of the message.
- in_bytes  in  4  valid bytes in a last word, 0..8, MSB-aligned; ignored when in_last=0; values >8 treated as 8.
- blk_valid  out  1  rate block available.
- blk_ready  in  1  permutation core accepts block.
- blk_data  out  1088  rate block; word 0 occupies bits [1087:1024].
- blk_first  out  1  block is the first of its message.
- blk_last  out  1  block is the last absorb block of its message.

## Operation
- States: FILL, EMIT, EMIT_NEXT.
- FILL: in_ready=1, blk_valid=0. Each accepted word is written to word slot `ptr` (0..16) of the assemble register, and `ptr` increments.
- Accepted word with in_last=0 and ptr=16: the block is full, non-final. Go to EMIT with blk_last=0, then reset ptr to 0.
- Accepted word with in_last=1:
  - Mask bytes beyond in_bytes to zero.
  - Compute len = ptr*64 + in_bytes*8 (11 bits, 0..1088).
  - Drive `pad` with data_in = assembled block and data_length = len.
  - Register `pad` data_out into the output register and data_next into the spill register.
  - Set ovf = (len == 1088).
  - Go to EMIT with blk_last = !ovf.
- EMIT: blk_valid=1, in_ready=0. On blk_ready:
  - Non-final block: go to FILL.
  - Final block with ovf: go to EMIT_NEXT.
  - Final block without ovf: go to FILL and set the first flag.
- EMIT_NEXT:
  - blk_data = spill register, blk_first=0, blk_last=1.
  - On blk_ready, go to FILL and set the first flag.
- blk_first = the first flag, latched when a block enters EMIT. The first flag sets on reset and on message end, and clears once a block is emitted.
- Empty message (in_last=1, in_bytes=0 at ptr=0) produces one block, with blk_first=blk_last=1.
- Zero-byte last word at ptr>0 is legal: len = ptr*64.
- blk_data, blk_first and blk_last are held stable while blk_valid=1 and blk_ready=0.
- in_valid during EMIT or EMIT_NEXT is not accepted (in_ready=0); the source holds it.

## Timing
- Reset values:
  - in_ready=1, blk_valid=0, blk_data=0, blk_first=0, blk_last=0.
  - State FILL, ptr=0, first flag=1, ovf=0.
- Assertion of rst_n mid-message or mid-EMIT discards all partial state immediately (asynchronous).
- Output latency: blk_valid rises the cycle after the accepting handshake of word 16 or the last word.
- Minimum cycles per full block: 17 input + 1 emit.
- Final spill block follows 1 cycle after the first final block's handshake if blk_ready stays high.
- `pad` is combinational and sits between the assemble register and the output/spill registers. No combinational path from blk_ready to in_ready beyond the state register.

## Configuration
- SHAKE_ABSORB_STATS_EN defined: adds output blk_count [15:0].
  - Increments on every blk_valid && blk_ready, wraps at 16'hFFFF→0, reset 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package shake256_pkg holds:
  - RATE_BITS, WORD_BITS, RATE_WORDS (17), LEN_BITS (11).
  - typedef rate_t logic [1087:0].
  - typedef enum absorb_state_t {FILL, EMIT, EMIT_NEXT}.
- Instantiates existing `pad` once as the only sub-module.

## Test plan
- Empty message: one word, in_last=1, in_bytes=0 → one block; blk_first=blk_last=1; blk_data equals `pad` output for data_in=0, length 0.
- 5-byte message: one word, in_bytes=5 → one block; bits [1087:1048] equal message bytes and bits [1047:1024] hold only pad-defined bits; data_length driven as 40.
- 136-byte message (17 words, last in_bytes=8):
  - Two blocks.
  - Block 1: message, blk_first=1, blk_last=0.
  - Block 2: `pad` data_next, blk_first=0, blk_last=1.
- 200-byte message (25 words, last in_bytes=8):
  - Block 1 is full, non-final, blk_first=1.
  - Block 2 is padded with len=512, blk_last=1.
  - Exactly two blocks.
- Backpressure: hold blk_ready=0 for 10 cycles in EMIT → blk_data stable, in_ready=0, no words accepted; release → single handshake.
- Reset: assert rst_n=0 after 9 words accepted → outputs to reset values. A new 8-byte message afterwards yields one block with blk_first=1. With SHAKE_ABSORB_STATS_EN, blk_count returns to 0 and then reads 1.
